bcd2bin: RTL and testbench

Sequential 4-digit BCD to 13-bit binary converter using reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8). It is the inverse of the existing `bin2bcd` block and uses the same `start`/`ready`/`done_tick` handshake. It sits between keypad or decimal-entry logic and binary datapaths. Over-range values and illegal digits are reported on `err`.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_sub3.sv | 10 +
 rtl/bcd2bin.sv | 98 +++++++++
 tb/tb_bcd2bin.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD/binary converter blocks.
// bin2bcd and bcd2bin both draw their widths and FSM encodings from here.
package bcd_pkg;

  localparam int BIN_W      = 13;
  localparam int BCD_DIGITS = 4;
  localparam int N_SHIFT    = 14;
  localparam int CNT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t OP   = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble digit corrector: a digit of 8 or more after the
// right shift had a ten carried in from above, so take 3 back off.
module bcd_sub3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble).
// One bit leaves the BCD register per cycle; the result lands after 14 shifts.
module bcd2bin
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  output logic             ready,
  output logic             done_tick,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  localparam int BCD_W = 4 * BCD_DIGITS;

  state_t             state;
  state_t             state_next;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_next;
  logic [N_SHIFT-1:0] bin_reg;
  logic [N_SHIFT-1:0] bin_next;
  logic [CNT_W-1:0]   n;
  logic               bad;
  logic               last;

  assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
  assign bin_next  = {bcd_reg[0], bin_reg[N_SHIFT-1:1]};
  assign last      = (n == CNT_W'(1));

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_sub3 u_sub3 (
      .din  (bcd_shift[4*g +: 4]),
      .dout (bcd_next[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = OP;
      OP:      if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    done_tick = (state == DONE);
  end

  // The output registers load from bin_next on the final shift, so the
  // result is already valid during the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      n       <= '0;
      bad     <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= {bcd3, bcd2, bcd1, bcd0};
            bin_reg <= '0;
            n       <= CNT_W'(N_SHIFT);
            bad     <= (bcd3 > 4'd9) || (bcd2 > 4'd9) ||
                       (bcd1 > 4'd9) || (bcd0 > 4'd9);
          end
        end
        OP: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          n       <= n - CNT_W'(1);
          if (last) begin
            bin <= bad ? '0 : bin_next[BIN_W-1:0];
            err <= bad | bin_next[N_SHIFT-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: expected {err,bin} pushed at launch,
// popped and compared when done_tick appears.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic        ready, done_tick, err;
  logic [12:0] bin;

  int total = 0;
  int bad = 0;
  int cycle_cnt = 0;
  int done_cnt = 0;
  int t0 = 0;
  logic [13:0] sb[$];

  bcd2bin dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .ready     (ready),
    .done_tick (done_tick),
    .bin       (bin),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (done_tick) done_cnt <= done_cnt + 1;
  end

  function automatic logic [13:0] model(input int d3, input int d2, input int d1, input int d0);
    int v;
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return {1'b1, 13'd0};
    v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    return {(v >= 8192) ? 1'b1 : 1'b0, v[12:0]};
  endfunction

  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    bcd3 = a; bcd2 = b; bcd1 = c; bcd0 = d;
    start = 1'b1;
    sb.push_back(model(a, b, c, d));
    @(negedge clk);
    start = 1'b0;
    t0 = cycle_cnt;
  endtask

  task automatic wait_done(output int lat, output logic to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done_tick) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    lat = cycle_cnt - t0 + 1;
  endtask

  task automatic test_reset();
    int lat; logic to; logic [13:0] exp;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_tick); end
    total++; if (bin !== 13'd0) begin bad++; $display("FAIL rst_bin: got %h want 0", bin); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 1'b1;
    launch(4'd1, 4'd2, 4'd3, 4'd4);
    wait_done(lat, to);
    exp = sb.pop_front();
    total++; if (to || lat !== 15) begin bad++; $display("FAIL first_latency: got %0d (timeout=%b) want 15", lat, to); end
    total++; if ({err, bin} !== exp || exp !== 14'h04D2) begin bad++; $display("FAIL first_value: got err=%b bin=%h want err=0 bin=04d2", err, bin); end
    @(negedge clk);
    total++; if (done_tick !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL done_pulse: got done=%b ready=%b want 0/1", done_tick, ready); end
    total++; if (bin !== 13'h04D2) begin bad++; $display("FAIL bin_hold: got %h want 04d2", bin); end
  endtask

  task automatic test_boundary();
    logic [15:0] vecs[4] = '{16'h0000, 16'h8191, 16'h8192, 16'h9999};
    logic [13:0] want[4] = '{14'h0000, 14'h1FFF, 14'h2000, 14'h270F};
    int lat; logic to; logic [13:0] exp; logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      launch(v[15:12], v[11:8], v[7:4], v[3:0]);
      wait_done(lat, to);
      exp = sb.pop_front();
      total++; if (to || lat !== 15) begin bad++; $display("FAIL bound_lat_%h: got %0d want 15", v, lat); end
      total++; if ({err, bin} !== exp || exp !== want[i]) begin bad++; $display("FAIL bound_val_%h: got err=%b bin=%h want %h", v, err, bin, want[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] vecs[2] = '{16'h000A, 16'hF000};
    int lat; logic to; logic [13:0] exp; logic [15:0] v;
    for (int i = 0; i < 2; i++) begin
      v = vecs[i];
      launch(v[15:12], v[11:8], v[7:4], v[3:0]);
      wait_done(lat, to);
      exp = sb.pop_front();
      total++; if (to || lat !== 15) begin bad++; $display("FAIL illegal_lat_%h: got %0d want 15", v, lat); end
      total++; if ({err, bin} !== exp || exp !== 14'h2000) begin bad++; $display("FAIL illegal_val_%h: got err=%b bin=%h want err=1 bin=0", v, err, bin); end
    end
  endtask

  task automatic test_busy();
    int lat; int n0; logic to; logic [13:0] exp;
    launch(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", ready); end
    bcd3 = 4'd9; bcd2 = 4'd8; bcd1 = 4'd7; bcd0 = 4'd6;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    bcd3 = 4'd5; bcd2 = 4'd5; bcd1 = 4'd5; bcd0 = 4'd5;
    wait_done(lat, to);
    exp = sb.pop_front();
    total++; if (to || lat !== 15) begin bad++; $display("FAIL busy_lat: got %0d want 15", lat); end
    total++; if ({err, bin} !== exp) begin bad++; $display("FAIL busy_val: got err=%b bin=%h want %h", err, bin, exp); end
    @(negedge clk);
    n0 = done_cnt;
    repeat (20) @(negedge clk);
    total++; if (done_cnt !== n0) begin bad++; $display("FAIL busy_extra_done: got %0d want %0d", done_cnt, n0); end
  endtask

  task automatic test_back_to_back();
    int lat; int prev; int n0; logic to; logic [13:0] exp;
    @(negedge clk);
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd4; bcd0 = 4'd2;
    start = 1'b1;
    t0 = cycle_cnt + 1;
    prev = 0;
    repeat (3) sb.push_back(model(0, 0, 4, 2));
    for (int k = 0; k < 3; k++) begin
      wait_done(lat, to);
      exp = sb.pop_front();
      if (k == 0) begin
        total++; if (to || lat !== 15) begin bad++; $display("FAIL b2b_lat: got %0d want 15", lat); end
      end else begin
        total++; if (to || cycle_cnt - prev !== 16) begin bad++; $display("FAIL b2b_period_%0d: got %0d want 16", k, cycle_cnt - prev); end
      end
      total++; if ({err, bin} !== exp || bin !== 13'd42) begin bad++; $display("FAIL b2b_val_%0d: got err=%b bin=%0d want 42", k, err, bin); end
      prev = cycle_cnt;
      if (k == 2) start = 1'b0;
      @(negedge clk);
    end
    n0 = done_cnt;
    repeat (20) @(negedge clk);
    total++; if (done_cnt !== n0 || ready !== 1'b1) begin bad++; $display("FAIL b2b_stop: got done_cnt=%0d ready=%b want %0d/1", done_cnt, ready, n0); end
  endtask

  task automatic test_reset_mid();
    int lat; int n0; logic to; logic [13:0] exp;
    n0 = done_cnt;
    launch(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    total++; if (ready !== 1'b1 || done_tick !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl: got ready=%b done=%b want 1/0", ready, done_tick); end
    total++; if (bin !== 13'd0 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got bin=%h err=%b want 0/0", bin, err); end
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (done_cnt !== n0) begin bad++; $display("FAIL mid_rst_nodone: got %0d want %0d", done_cnt, n0); end
    launch(4'd9, 4'd9, 4'd9, 4'd9);
    wait_done(lat, to);
    exp = sb.pop_front();
    total++; if (to || lat !== 15) begin bad++; $display("FAIL post_rst_lat: got %0d want 15", lat); end
    total++; if ({err, bin} !== exp || exp !== 14'h270F) begin bad++; $display("FAIL post_rst_val: got err=%b bin=%h want err=1 bin=070f", err, bin); end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_illegal();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
